inv_key_schedule: RTL and testbench

Sequential AES key schedule for the decryption datapath. Accepts an AES-128/192/256 cipher key, expands it one 32-bit word per clock into an internal word buffer, then streams the 128-bit round keys in reverse order (round Nr down to round 0) over a valid/ready interface. It sits between key load and the inverse-cipher round engine and complements the combinational forward key expansion used by the encryption path.

---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/aes_sub_word.sv | 12 +
 rtl/inv_key_schedule.sv | 152 +++++++++++++++
 tb/tb_inv_key_schedule.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, lookups, FSM state type, S-box and InvMixColumns helpers
// Feature macro: INV_MIXCOL_EN enables the inv_mix_columns helper.
package aes_pkg;

    localparam logic [1:0] ALG_128  = 2'd0;
    localparam logic [1:0] ALG_192  = 2'd1;
    localparam logic [1:0] ALG_256  = 2'd2;
    localparam logic [1:0] ALG_RSVD = 2'd3;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, SERVE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [3:0] nk_of(input logic [1:0] a);
        return a == ALG_256 ? 4'd8 : a == ALG_192 ? 4'd6 : 4'd4;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] a);
        return a == ALG_256 ? 4'd14 : a == ALG_192 ? 4'd12 : 4'd10;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

`ifdef INV_MIXCOL_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {imc_col(s[127:96]), imc_col(s[95:64]), imc_col(s[63:32]), imc_col(s[31:0])};
    endfunction
`endif

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational 4-byte AES S-box
// Ports: in_word (32) word to substitute, out_word (32) substituted word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    assign out_word = sub_word(in_word);

endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: sequential AES-128/192/256 key expansion streaming round keys Nr..0
// Ports: clk, rst (sync, active high); key_in/algorithm/start request; busy, err status;
// rk_valid/rk_ready/rk_out/rk_round/rk_last round-key stream; done end-of-stream pulse.
// Feature macro: INV_MIXCOL_EN applies InvMixColumns to rounds 1..Nr-1.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic [1:0]   algorithm,
    input  logic         start,
    output logic         busy,
    output logic         err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         done
);

    state_t state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [3:0] nk_q, nk_d, nr_q, nr_d, rc_q, rc_d, r_q, r_d;
    logic [5:0] i_q, i_d, base;
    logic [2:0] k_q, k_d;
    logic rk_valid_q, rk_valid_d, err_q, err_d, done_q, done_d, load, we_load, we_exp;
    logic [127:0] rk_out_q, rk_out_d, raw;
    logic [31:0] w_q [60];
    logic [31:0] prev, sw_in, sw_out, temp, new_w;

    // k_q tracks i mod Nk and rc_q tracks i/Nk-1, avoiding dividers
    assign prev  = w_q[i_q - 6'd1];
    assign sw_in = k_q == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    assign temp  = k_q == 3'd0 ? sw_out ^ {RCON[rc_q], 24'h0} :
                   (nk_q == 4'd8 && k_q == 3'd4) ? sw_out : prev;
    assign new_w = w_q[i_q - {2'b00, nk_q}] ^ temp;

    aes_sub_word u_sub_word (.in_word(sw_in), .out_word(sw_out));

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        i_d        = i_q;
        k_d        = k_q;
        rc_d       = rc_q;
        r_d        = r_q;
        rk_valid_d = rk_valid_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;
        we_load    = 1'b0;
        we_exp     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d = algorithm == ALG_RSVD;
                if (algorithm != ALG_RSVD) begin
                    key_d   = key_in;
                    nk_d    = nk_of(algorithm);
                    nr_d    = nr_of(algorithm);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                we_load = 1'b1;
                i_d     = {2'b00, nk_q};
                k_d     = 3'd0;
                rc_d    = 4'd0;
                state_d = EXPAND;
            end
            EXPAND: begin
                we_exp  = 1'b1;
                i_d     = i_q + 6'd1;
                k_d     = {1'b0, k_q} == nk_q - 4'd1 ? 3'd0 : k_q + 3'd1;
                rc_d    = k_q == 3'd0 ? rc_q + 4'd1 : rc_q;
                state_d = i_q == {nr_q, 2'b11} ? SERVE : EXPAND;
            end
            SERVE: begin
                // first SERVE cycle fetches round Nr, after w[4Nr+3] has landed
                if (!rk_valid_q) begin
                    rk_valid_d = 1'b1;
                    r_d        = nr_q;
                    load       = 1'b1;
                end else if (rk_ready) begin
                    if (r_q != 4'd0) begin
                        r_d  = r_q - 4'd1;
                        load = 1'b1;
                    end else begin
                        rk_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        base = {r_d, 2'b00};
        raw  = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
`ifdef INV_MIXCOL_EN
        rk_out_d = !load ? rk_out_q : (r_d != 4'd0 && r_d != nr_q) ? inv_mix_columns(raw) : raw;
`else
        rk_out_d = load ? raw : rk_out_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            i_q        <= 6'd0;
            k_q        <= 3'd0;
            rc_q       <= 4'd0;
            r_q        <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= 128'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            i_q        <= i_d;
            k_q        <= k_d;
            rc_q       <= rc_d;
            r_q        <= r_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        key_q <= key_d;
        for (int j = 0; j < 8; j++)
            if (we_load && 4'(j) < nk_q) w_q[j] <= key_q[255 - 32 * j -: 32];
        if (we_exp) w_q[i_q] <= new_w;
    end

    assign busy     = state_q != IDLE;
    assign err      = err_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_round = r_q;
    assign rk_last  = rk_valid_q && r_q == 4'd0;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: directed self-checking bench for inv_key_schedule
module tb_inv_key_schedule;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, rk_ready = 1'b0;
    logic [255:0] key_in = '0;
    logic [1:0] algorithm = 2'd0;
    logic busy, err, rk_valid, rk_last, done;
    logic [127:0] rk_out;
    logic [3:0] rk_round;
    int total = 0, bad = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    inv_key_schedule dut (
        .clk(clk), .rst(rst), .key_in(key_in), .algorithm(algorithm), .start(start),
        .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round), .rk_last(rk_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".rk_valid"}, rk_valid, 0);
        chk({tag, ".rk_out"}, rk_out, 0);
        chk({tag, ".rk_round"}, rk_round, 0);
        chk({tag, ".rk_last"}, rk_last, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    task automatic run(input string tag, input logic [1:0] alg, input logic [255:0] key,
                       input int nr, input int lat, input logic [127:0] k_top, input int one_r,
                       input logic [127:0] k_one, input logic [127:0] k_zero, input bit rnd);
        int cyc, r, ticks, xfers;
        logic [127:0] snap;
        logic rdy;
        algorithm = alg;
        key_in = key;
        start = 1'b1;
        tick;
        start = 1'b0;
        key_in = ~key;
        chk({tag, ".busy_rise"}, busy, 1);
        cyc = 0;
        while (!rk_valid && cyc < 100) begin
            tick;
            cyc++;
        end
        chk({tag, ".latency"}, cyc, lat);
        chk({tag, ".first_round"}, rk_round, nr);
        chk({tag, ".first_key"}, rk_out, k_top);
        r = nr;
        ticks = 0;
        xfers = 0;
        while (xfers <= nr && ticks < 300) begin
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, ".valid"}, rk_valid, 1);
            chk({tag, ".round"}, rk_round, r);
            chk({tag, ".last"}, rk_last, r == 0);
            chk({tag, ".no_early_done"}, done, 0);
`ifndef INV_MIXCOL_EN
            if (r == one_r) chk({tag, ".mid_key"}, rk_out, k_one);
`endif
            if (r == 0) chk({tag, ".final_key"}, rk_out, k_zero);
            snap = rk_out;
            rdy = rk_ready;
            tick;
            ticks++;
            if (rdy) begin
                xfers++;
                if (r > 0) r--;
            end else chk({tag, ".stall_stable"}, rk_out, snap);
        end
        rk_ready = 1'b0;
        chk({tag, ".transfers"}, xfers, nr + 1);
        if (!rnd) chk({tag, ".serve_cycles"}, ticks, nr + 1);
        chk({tag, ".done_pulse"}, done, 1);
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".valid_drop"}, rk_valid, 0);
        tick;
        chk({tag, ".done_clear"}, done, 0);
    endtask

    initial begin
        int cyc;
        logic seen;
        tick;
        tick;
        chk_reset("reset");
        rst = 1'b0;
        tick;

        run("aes128", 2'd0, K128, 10, 42, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
            1, 128'ha0fafe1788542cb123a339392a6c7605, K128[255:128], 1'b0);
        run("aes192", 2'd1, K192, 12, 48, 128'he98ba06f448c773c8ecc720401002202,
            -1, 128'h0, K192[255:128], 1'b0);
        run("aes256", 2'd2, K256, 14, 54, 128'hfe4890d1e6188d0b046df344706c631e,
            -1, 128'h0, K256[255:128], 1'b1);

        algorithm = 2'd3;
        key_in = K128;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("rsvd.err", err, 1);
        chk("rsvd.busy", busy, 0);
        tick;
        chk("rsvd.err_clear", err, 0);
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            seen = seen | rk_valid | busy;
            tick;
        end
        chk("rsvd.no_activity", seen, 0);

        algorithm = 2'd0;
        key_in = K128;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (20) tick;
        chk("rst_exp.busy_before", busy, 1);
        rst = 1'b1;
        tick;
        chk_reset("rst_exp");
        rst = 1'b0;
        tick;
        chk("rst_exp.idle_after", busy, 0);

        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 0;
        while (!rk_valid && cyc < 100) begin
            tick;
            cyc++;
        end
        chk("rst_srv.latency", cyc, 42);
        rk_ready = 1'b1;
        tick;
        tick;
        rk_ready = 1'b0;
        chk("rst_srv.round_before", rk_round, 8);
        rst = 1'b1;
        tick;
        chk_reset("rst_srv");
        rst = 1'b0;
        tick;

        run("aes128_again", 2'd0, K128, 10, 42, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
            1, 128'ha0fafe1788542cb123a339392a6c7605, K128[255:128], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
